aes_ecb_decrypt: RTL and testbench

//  Iterative AES-128 ECB decryptor: one inverse round per clock with an on-the-fly inverse key schedule.

---
 rtl/aes_ecb_decrypt.sv | 271 +++++++++++++++++++++++++++
 tb/tb_aes_ecb_decrypt.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ecb_decrypt.sv
// aes_ecb_decrypt
//   Iterative AES-128 ECB decryptor. One inverse round is computed per clock.
//   The forward key schedule is first run up to rk10. The inverse schedule
//   then walks back from rk10 to rk0 alongside the rounds.
//   State byte 0 is bit [127:120] (FIPS-197 ordering).
//
// Parameters
//   OUT_HOLD        1: decrypted_text holds until the next done
//                   0: decrypted_text clears to 0 when a new run is accepted
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   run             start request, sampled only while idle
//   key             128-bit cipher key, captured with run
//   cipher_text     128-bit ciphertext, captured with run
//   decrypted_text  recovered plaintext (registered)
//   done            one-cycle pulse, decrypted_text valid
//   busy            high from the accepting edge until the done edge
//
// Build option
//   AES_DEC_KEY_CACHE_EN  caches the last key and its rk10.
//                         A repeated key skips the forward expansion.
//                         The latency then drops from 21 to 11 clocks.

module aes_ecb_decrypt #(
    parameter int OUT_HOLD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [127:0] key,
    input  logic [127:0] cipher_text,
    output logic [127:0] decrypted_text,
    output logic         done,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] isb(input logic [7:0] b);
        return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w))
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = rk[127:96] ^ sub_rot(rk[31:0]) ^ {rc, 24'h0};
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undoes one forward step. The previous w3 is recovered first because
    // the previous w0 depends on it.
    function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0] ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    // Row r of column c takes its byte from column (c - r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c-r+4)%4)+r)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = isb(s[8*i +: 8]);
        end
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (9, 11, 13 or 14).
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^
               (m[1] ? x2 : 8'h00) ^ (m[0] ? b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*(3-c)+24 +: 8];
            a1 = s[32*(3-c)+16 +: 8];
            a2 = s[32*(3-c)+8  +: 8];
            a3 = s[32*(3-c)    +: 8];
            o[32*(3-c)+24 +: 8] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
            o[32*(3-c)+16 +: 8] = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
            o[32*(3-c)+8  +: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
            o[32*(3-c)    +: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
        end
        return o;
    endfunction

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [127:0] r_rk;
    logic [127:0] r_st;
    logic [127:0] r_ct;
    logic [127:0] r_out;
    logic         r_done;
    logic         r_busy;
`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] r_key;
    logic [127:0] r_cache_key;
    logic [127:0] r_cache_rk;
    logic         r_cache_vld;
`endif

    logic [127:0] w_fwd_rk;
    logic [7:0]   w_inv_rcon;
    logic [127:0] w_inv_rk;
    logic [127:0] w_add;
    logic [127:0] w_round;

    assign w_fwd_rk   = fwd_expand(r_rk, rcon(r_cnt));
    // INIT steps rk10 -> rk9. At that point r_cnt is not yet 10 on every path.
    assign w_inv_rcon = (r_state == S_INIT) ? 8'h36 : rcon(r_cnt);
    assign w_inv_rk   = inv_expand(r_rk, w_inv_rcon);
    assign w_add      = inv_sub_bytes(inv_shift_rows(r_st)) ^ r_rk;
    assign w_round    = inv_mix_columns(w_add);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rk    <= '0;
            r_st    <= '0;
            r_ct    <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            r_key       <= '0;
            r_cache_key <= '0;
            r_cache_rk  <= '0;
            r_cache_vld <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_ct   <= cipher_text;
                        r_busy <= 1'b1;
                        if (OUT_HOLD == 0) r_out <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
                        r_key <= key;
                        if (r_cache_vld && (key == r_cache_key)) begin
                            r_rk    <= r_cache_rk;
                            r_state <= S_INIT;
                        end else begin
                            r_rk    <= key;
                            r_cnt   <= 4'd1;
                            r_state <= S_KEYEXP;
                        end
`else
                        r_rk    <= key;
                        r_cnt   <= 4'd1;
                        r_state <= S_KEYEXP;
`endif
                    end
                end
                S_KEYEXP: begin
                    r_rk  <= w_fwd_rk;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd10) begin
                        r_state <= S_INIT;
`ifdef AES_DEC_KEY_CACHE_EN
                        r_cache_key <= r_key;
                        r_cache_rk  <= w_fwd_rk;
                        r_cache_vld <= 1'b1;
`endif
                    end
                end
                S_INIT: begin
                    r_st    <= r_ct ^ r_rk;
                    r_rk    <= w_inv_rk;
                    r_cnt   <= 4'd9;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_rk <= w_inv_rk;
                    if (r_cnt == 4'd0) begin
                        // The last round has no InvMixColumns.
                        r_out   <= w_add;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_st  <= w_round;
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign decrypted_text = r_out;
    assign done           = r_done;
    assign busy           = r_busy;

endmodule

// File: tb/tb_aes_ecb_decrypt.sv
// tb_aes_ecb_decrypt
//   Directed bench for aes_ecb_decrypt using known-answer AES-128 vectors.
//   It covers latency, the busy and done shapes, and output hold.
//   It also covers an ignored mid-run request, a run held high, async reset
//   during an operation, and the key cache (when AES_DEC_KEY_CACHE_EN is set).

module tb_aes_ecb_decrypt;

    localparam int NO_POKE = -2;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
    localparam int LAT_HIT = 11;
`else
    localparam bit CACHE = 1'b0;
    localparam int LAT_HIT = 21;
`endif

    logic         clk;
    logic         rst;
    logic         run;
    logic [127:0] key;
    logic [127:0] cipher_text;
    logic [127:0] decrypted_text;
    logic         done;
    logic         busy;

    aes_ecb_decrypt #(.OUT_HOLD(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .key            (key),
        .cipher_text    (cipher_text),
        .decrypted_text (decrypted_text),
        .done           (done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [7];

    int           n_applied = 0;
    int           n_miss    = 0;
    logic [127:0] mkey      = '0;
    bit           mvalid    = 1'b0;
    logic [127:0] prev_pt   = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_applied++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [127:0] k);
        return (CACHE && mvalid && (k == mkey)) ? 11 : 21;
    endfunction

    // Called #1 after the accepting edge. Counts the edges until done is seen.
    task automatic wait_done(input int poke_at, input logic [127:0] pk, input logic [127:0] pc,
                             output int lat, output int bcnt, output logic [127:0] res);
        lat  = 0;
        bcnt = 0;
        res  = '0;
        while (lat < 60) begin
            if (busy) bcnt++;
            if (done) begin
                res = decrypted_text;
                break;
            end
            if (lat == 3) chk("hold_during_run", decrypted_text, prev_pt);
            if (lat == poke_at) begin
                run         = 1'b1;
                key         = pk;
                cipher_text = pc;
            end
            if (lat == poke_at + 1) run = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [127:0] k, input logic [127:0] c,
                         output int lat, output int bcnt, output logic [127:0] res);
        @(negedge clk);
        run         = 1'b1;
        key         = k;
        cipher_text = c;
        @(posedge clk);
        #1;
        run         = 1'b0;
        key         = ~k;
        cipher_text = ~c;
        wait_done(NO_POKE, '0, '0, lat, bcnt, res);
    endtask

    task automatic check_op(input string nm, input logic [127:0] k, input logic [127:0] c,
                            input logic [127:0] pt, output int lat);
        int           el;
        int           bcnt;
        logic [127:0] res;
        el = exp_lat(k);
        do_op(k, c, lat, bcnt, res);
        chki({nm, "_latency"}, lat, el);
        chki({nm, "_busy_cycles"}, bcnt, el);
        chk({nm, "_plaintext"}, res, pt);
        @(posedge clk);
        #1;
        chk({nm, "_done_width"}, {127'b0, done}, 128'b0);
        chk({nm, "_out_held"}, decrypted_text, pt);
        mkey    = k;
        mvalid  = 1'b1;
        prev_pt = pt;
    endtask

    initial begin
        int           lat;
        int           lat2;
        int           bcnt;
        int           dcnt;
        logic [127:0] res;

        vecs[0] = '{"c1",   128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{"appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{"sp1",  128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
        vecs[3] = '{"sp2",  128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
        vecs[4] = '{"sp3",  128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h43b1cd7f598ece23881b00e3ed030688, 128'h30c81c46a35ce411e5fbc1191a0a52ef};
        vecs[5] = '{"sp4",  128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h7b0c785e27e8ad3f8223207104725dd4, 128'hf69f2445df4f9b17ad2b417be66c3710};
        vecs[6] = '{"zero", 128'h0,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

        rst         = 1'b0;
        run         = 1'b0;
        key         = '0;
        cipher_text = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", decrypted_text, '0);
        chk("reset_done_busy", {126'b0, done, busy}, '0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            check_op(vecs[i].name, vecs[i].key, vecs[i].ct, vecs[i].pt, lat);
        end

        // A request during an operation is dropped, not queued.
        @(negedge clk);
        run         = 1'b1;
        key         = vecs[0].key;
        cipher_text = vecs[0].ct;
        @(posedge clk);
        #1;
        run = 1'b0;
        wait_done(5, vecs[1].key, vecs[1].ct, lat, bcnt, res);
        chki("ignored_run_latency", lat, exp_lat(vecs[0].key));
        chk("ignored_run_plaintext", res, vecs[0].pt);
        mkey    = vecs[0].key;
        mvalid  = 1'b1;
        prev_pt = vecs[0].pt;
        @(posedge clk);
        #1;
        chk("ignored_run_not_queued", {127'b0, busy}, '0);

        // run held high: the next operation starts on the edge after done.
        @(negedge clk);
        run         = 1'b1;
        key         = vecs[0].key;
        cipher_text = vecs[0].ct;
        @(posedge clk);
        #1;
        wait_done(NO_POKE, '0, '0, lat, bcnt, res);
        chki("held_run_first_latency", lat, exp_lat(vecs[0].key));
        chk("held_run_first_plaintext", res, vecs[0].pt);
        mkey    = vecs[0].key;
        mvalid  = 1'b1;
        @(posedge clk);
        #1;
        chk("held_run_reaccepted", {127'b0, busy}, 128'b1);
        wait_done(NO_POKE, '0, '0, lat2, bcnt, res);
        run = 1'b0;
        chki("held_run_second_latency", lat2, exp_lat(vecs[0].key));
        chk("held_run_second_plaintext", res, vecs[0].pt);
        @(posedge clk);
        #1;
        chk("held_run_released_idle", {127'b0, busy}, '0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        run         = 1'b1;
        key         = vecs[0].key;
        cipher_text = vecs[0].ct;
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_out", decrypted_text, '0);
        chk("async_reset_done_busy", {126'b0, done, busy}, '0);
        @(negedge clk);
        rst     = 1'b1;
        mvalid  = 1'b0;
        prev_pt = '0;
        dcnt    = 0;
        bcnt    = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        chki("after_reset_no_done", dcnt, 0);
        chki("after_reset_no_busy", bcnt, 0);
        check_op("post_reset_appb", vecs[1].key, vecs[1].ct, vecs[1].pt, lat);
        chki("post_reset_full_latency", lat, 21);

        // Key cache: miss, hit, then miss on a different key.
        check_op("cache_a", vecs[0].key, vecs[0].ct, vecs[0].pt, lat);
        chki("cache_a_latency", lat, 21);
        check_op("cache_b", vecs[0].key, vecs[0].ct, vecs[0].pt, lat);
        chki("cache_b_latency", lat, LAT_HIT);
        check_op("cache_c", vecs[1].key, vecs[1].ct, vecs[1].pt, lat);
        chki("cache_c_latency", lat, 21);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
